// File: rtl/e32_host_pkg.sv
// Shared definitions for the E32 host controller: command opcodes, error
// codes, FSM states, header/opcode bytes and default timing constants.
package e32_host_pkg;

  typedef enum logic [2:0] {
    OP_SAVE_CFG = 3'd0,
    OP_VOL_CFG  = 3'd1,
    OP_READ_CFG = 3'd2,
    OP_READ_VER = 3'd3,
    OP_RESET    = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER_PROG,
    ST_SEND,
    ST_WAIT_RESP,
    ST_WAIT_AUX,
    ST_EXIT_PROG,
    ST_DONE
  } state_e;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_AUX_TO  = 3'd1;
  localparam logic [2:0] ERR_RESP_TO = 3'd2;
  localparam logic [2:0] ERR_HDR     = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL = 3'd4;

  localparam logic [7:0] HDR_SAVE_CFG = 8'hC0;
  localparam logic [7:0] HDR_VOL_CFG  = 8'hC2;
  localparam logic [7:0] HDR_RET_CFG  = 8'hC1;
  localparam logic [7:0] HDR_RET_VER  = 8'hC3;
  localparam logic [7:0] HDR_RESET    = 8'hC4;

  localparam int END_MODE_SWITCH_DEF  = 15000;
  localparam int END_AUX_TIMEOUT_DEF  = 3000000;
  localparam int END_RESP_TIMEOUT_DEF = 750000;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'(OP_RESET);
  endfunction

endpackage

// File: rtl/e32_host_controller_if.sv
// Byte-stream link between the host controller and the external com_uart.
//   tx_data/tx_valid/tx_ready : byte to transmit, held until accepted
//   rx_data/rx_valid          : received byte, one-cycle strobe
// master = controller side, slave = UART side.
interface e32_host_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/e32_aux_wait.sv
// AUX synchronizer plus the single 24-bit wait/timeout counter used for every
// wait in the controller.
//   start_i     : (re)start a wait; check_aux_i/target_i/limit_i are captured
//   check_aux_i : 1 = wait for synchronized AUX == target_i, 0 = pure delay
//   hit_o       : AUX reached target (combinational while waiting)
//   timeout_o   : counter reached limit-1 without a hit (expiry for delays)
module e32_aux_wait
  import e32_host_pkg::*;
(
  input  logic        device_clk,
  input  logic        rst_n,
  input  logic        aux_async_i,
  input  logic        start_i,
  input  logic        check_aux_i,
  input  logic        target_i,
  input  logic [23:0] limit_i,
  output logic        hit_o,
  output logic        timeout_o
);

  logic [1:0]  sync_q;
  logic        active_q;
  logic        check_q;
  logic        target_q;
  logic [23:0] limit_q;
  logic [23:0] cnt_q;

  assign hit_o     = active_q & check_q & (sync_q[1] == target_q);
  assign timeout_o = active_q & ~hit_o & (cnt_q == limit_q - 24'd1);

  always_ff @(posedge device_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      active_q <= 1'b0;
      check_q  <= 1'b0;
      target_q <= 1'b0;
      limit_q  <= 24'd0;
      cnt_q    <= 24'd0;
    end else begin
      sync_q <= {sync_q[0], aux_async_i};
      if (start_i) begin
        active_q <= 1'b1;
        cnt_q    <= 24'd0;
        check_q  <= check_aux_i;
        target_q <= target_i;
        limit_q  <= limit_i;
      end else if (active_q) begin
        if (hit_o || timeout_o) active_q <= 1'b0;
        else                    cnt_q    <= cnt_q + 24'd1;
      end
    end
  end

endmodule

// File: rtl/e32_host_controller.sv
// MCU-side initiator for the E32 RF module: drives M0/M1, tracks AUX and runs
// the write-config / read-config / read-version / reset command protocol over
// a byte UART.
// Ports:
//   device_clk, rst_n      : clock, async active-low reset
//   op_mode                : {M1,M0} applied while idle
//   cmd_valid/cmd_ready    : command handshake, cmd_op + cfg_in latched
//   M0, M1, AUX            : module mode pins and (async) ready pin
//   uart (master)          : tx/rx byte stream to com_uart
//   cfg_out, ver_out       : last accepted config / version responses
//   done, err              : completion pulse and status code
// Optional build macro: E32_HOST_RESP_CHECK_EN enables response content
// checking (err=3 on mismatch).
//
// state       | meaning
// IDLE        | follow op_mode, accept commands
// ENTER_PROG  | M=11; sub0 wait AUX high, sub1 mode-switch settle delay
// SEND        | stream command bytes to the UART
// WAIT_RESP   | collect response bytes, inter-byte timeout
// WAIT_AUX    | sub0 wait AUX low (reset op only), sub1 wait AUX high
// EXIT_PROG   | M=op_mode; sub0 wait AUX high, sub1 settle delay
// DONE        | one-cycle done pulse
module e32_host_controller
  import e32_host_pkg::*;
#(
  parameter int                    DATA_WIDTH         = 8,
  parameter logic [DATA_WIDTH-1:0] HEAD_DETECT_1      = HDR_SAVE_CFG,
  parameter logic [DATA_WIDTH-1:0] HEAD_DETECT_2      = HDR_VOL_CFG,
  parameter logic [DATA_WIDTH-1:0] RET_CONFIG_DETECT  = HDR_RET_CFG,
  parameter logic [DATA_WIDTH-1:0] RET_VERSION_DETECT = HDR_RET_VER,
  parameter logic [DATA_WIDTH-1:0] RESET_DETECT       = HDR_RESET,
  parameter int                    END_MODE_SWITCH    = END_MODE_SWITCH_DEF,
  parameter int                    END_AUX_TIMEOUT    = END_AUX_TIMEOUT_DEF,
  parameter int                    END_RESP_TIMEOUT   = END_RESP_TIMEOUT_DEF
) (
  input  logic                    device_clk,
  input  logic                    rst_n,
  input  logic [1:0]              op_mode,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [5*DATA_WIDTH-1:0] cfg_in,
  output logic                    M0,
  output logic                    M1,
  input  logic                    AUX,
  e32_host_controller_if.master   uart,
  output logic [6*DATA_WIDTH-1:0] cfg_out,
  output logic [4*DATA_WIDTH-1:0] ver_out,
  output logic                    done,
  output logic [2:0]              err
);

  localparam int DW = DATA_WIDTH;
  localparam logic [23:0] LIM_MODE = 24'(END_MODE_SWITCH);
  localparam logic [23:0] LIM_AUX  = 24'(END_AUX_TIMEOUT);
  localparam logic [23:0] LIM_RESP = 24'(END_RESP_TIMEOUT);

  state_e           state_q, state_d;
  logic             sub_q, sub_d;
  logic [2:0]       op_q, op_d;
  logic [5*DW-1:0]  cfg_q, cfg_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       rxcnt_q, rxcnt_d;
  logic [5*DW-1:0]  sr_q, sr_d;
  logic [6*DW-1:0]  cfg_out_q, cfg_out_d;
  logic [4*DW-1:0]  ver_out_q, ver_out_d;
  logic [2:0]       err_q, err_d;
  logic [1:0]       mode_q, mode_d;
  logic             ready_q, ready_d;

  logic             wt_start, wt_check, wt_target, wt_hit, wt_timeout;
  logic [23:0]      wt_limit;

  logic             is_cfg, is_ver;
  logic [2:0]       tx_last, resp_last;
  logic [DW-1:0]    cmd_byte, tx_byte;
  logic             resp_ok;
  logic [2:0]       aux_err;

  e32_aux_wait u_aux_wait (
    .device_clk  (device_clk),
    .rst_n       (rst_n),
    .aux_async_i (AUX),
    .start_i     (wt_start),
    .check_aux_i (wt_check),
    .target_i    (wt_target),
    .limit_i     (wt_limit),
    .hit_o       (wt_hit),
    .timeout_o   (wt_timeout)
  );

  assign is_cfg    = (op_q == OP_SAVE_CFG) || (op_q == OP_VOL_CFG);
  assign is_ver    = (op_q == OP_READ_VER);
  assign tx_last   = is_cfg ? 3'd5 : 3'd2;
  assign resp_last = is_ver ? 3'd3 : 3'd5;
  // An AUX timeout never overwrites an error already recorded.
  assign aux_err   = (err_q == ERR_OK) ? ERR_AUX_TO : err_q;

  always_comb begin
    unique case (op_q)
      OP_SAVE_CFG: cmd_byte = HEAD_DETECT_1;
      OP_VOL_CFG:  cmd_byte = HEAD_DETECT_2;
      OP_READ_CFG: cmd_byte = RET_CONFIG_DETECT;
      OP_READ_VER: cmd_byte = RET_VERSION_DETECT;
      default:     cmd_byte = RESET_DETECT;
    endcase
  end

  always_comb begin
    tx_byte = cmd_byte;
    if (is_cfg) begin
      unique case (idx_q)
        3'd1:    tx_byte = cfg_q[5*DW-1 -: DW];
        3'd2:    tx_byte = cfg_q[4*DW-1 -: DW];
        3'd3:    tx_byte = cfg_q[3*DW-1 -: DW];
        3'd4:    tx_byte = cfg_q[2*DW-1 -: DW];
        3'd5:    tx_byte = cfg_q[DW-1:0];
        default: tx_byte = cmd_byte;
      endcase
    end
  end

  // Evaluated only on the final response byte: sr_q holds the earlier bytes
  // and uart.rx_data the last one.
`ifdef E32_HOST_RESP_CHECK_EN
  always_comb begin
    if (is_cfg)      resp_ok = ({sr_q, uart.rx_data} == {cmd_byte, cfg_q});
    else if (is_ver) resp_ok = (sr_q[3*DW-1 -: DW] == RET_VERSION_DETECT);
    else             resp_ok = (sr_q[5*DW-1 -: DW] == RET_CONFIG_DETECT);
  end
`else
  assign resp_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    op_d      = op_q;
    cfg_d     = cfg_q;
    idx_d     = idx_q;
    rxcnt_d   = rxcnt_q;
    sr_d      = sr_q;
    cfg_out_d = cfg_out_q;
    ver_out_d = ver_out_q;
    err_d     = err_q;
    mode_d    = mode_q;
    wt_start  = 1'b0;
    wt_check  = 1'b1;
    wt_target = 1'b1;
    wt_limit  = LIM_AUX;

    unique case (state_q)
      ST_IDLE: begin
        mode_d = op_mode;
        if (cmd_valid && ready_q) begin
          op_d  = cmd_op;
          cfg_d = cfg_in;
          err_d = ERR_OK;
          if (!op_legal(cmd_op)) begin
            err_d   = ERR_ILLEGAL;
            state_d = ST_DONE;
          end else begin
            mode_d   = 2'b11;
            state_d  = ST_ENTER_PROG;
            sub_d    = 1'b0;
            wt_start = 1'b1;
          end
        end
      end

      ST_ENTER_PROG: begin
        if (!sub_q) begin
          if (wt_hit) begin
            sub_d    = 1'b1;
            wt_start = 1'b1;
            wt_check = 1'b0;
            wt_limit = LIM_MODE;
          end else if (wt_timeout) begin
            err_d    = aux_err;
            mode_d   = op_mode;
            state_d  = ST_EXIT_PROG;
            sub_d    = 1'b0;
            wt_start = 1'b1;
          end
        end else if (wt_timeout) begin
          state_d = ST_SEND;
          idx_d   = 3'd0;
        end
      end

      ST_SEND: begin
        if (uart.tx_ready) begin
          if (idx_q == tx_last) begin
            wt_start = 1'b1;
            if (op_q == OP_RESET) begin
              state_d   = ST_WAIT_AUX;
              sub_d     = 1'b0;
              wt_target = 1'b0;
            end else begin
              state_d  = ST_WAIT_RESP;
              rxcnt_d  = 3'd0;
              wt_check = 1'b0;
              wt_limit = LIM_RESP;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      ST_WAIT_RESP: begin
        if (uart.rx_valid) begin
          sr_d     = {sr_q[4*DW-1:0], uart.rx_data};
          rxcnt_d  = rxcnt_q + 3'd1;
          wt_start = 1'b1;
          wt_check = 1'b0;
          wt_limit = LIM_RESP;
          if (rxcnt_q == resp_last) begin
            if (!resp_ok)    err_d     = ERR_HDR;
            else if (is_ver) ver_out_d = {sr_q[3*DW-1:0], uart.rx_data};
            else             cfg_out_d = {sr_q, uart.rx_data};
            state_d  = ST_WAIT_AUX;
            sub_d    = 1'b1;
            wt_check = 1'b1;
            wt_limit = LIM_AUX;
          end
        end else if (wt_timeout) begin
          err_d    = ERR_RESP_TO;
          mode_d   = op_mode;
          state_d  = ST_EXIT_PROG;
          sub_d    = 1'b0;
          wt_start = 1'b1;
        end
      end

      ST_WAIT_AUX: begin
        if (wt_timeout) begin
          err_d    = aux_err;
          mode_d   = op_mode;
          state_d  = ST_EXIT_PROG;
          sub_d    = 1'b0;
          wt_start = 1'b1;
        end else if (wt_hit) begin
          wt_start = 1'b1;
          if (!sub_q) begin
            sub_d = 1'b1;
          end else begin
            mode_d  = op_mode;
            state_d = ST_EXIT_PROG;
            sub_d   = 1'b0;
          end
        end
      end

      ST_EXIT_PROG: begin
        if (!sub_q) begin
          if (wt_hit || wt_timeout) begin
            if (wt_timeout) err_d = aux_err;
            sub_d    = 1'b1;
            wt_start = 1'b1;
            wt_check = 1'b0;
            wt_limit = LIM_MODE;
          end
        end else if (wt_timeout) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_d = (state_d == ST_IDLE);

  always_ff @(posedge device_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sub_q     <= 1'b0;
      op_q      <= 3'd0;
      cfg_q     <= '0;
      idx_q     <= 3'd0;
      rxcnt_q   <= 3'd0;
      sr_q      <= '0;
      cfg_out_q <= '0;
      ver_out_q <= '0;
      err_q     <= ERR_OK;
      mode_q    <= 2'b00;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      op_q      <= op_d;
      cfg_q     <= cfg_d;
      idx_q     <= idx_d;
      rxcnt_q   <= rxcnt_d;
      sr_q      <= sr_d;
      cfg_out_q <= cfg_out_d;
      ver_out_q <= ver_out_d;
      err_q     <= err_d;
      mode_q    <= mode_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd_ready     = ready_q;
  assign {M1, M0}      = mode_q;
  assign uart.tx_valid = (state_q == ST_SEND);
  assign uart.tx_data  = (state_q == ST_SEND) ? tx_byte : '0;
  assign cfg_out       = cfg_out_q;
  assign ver_out       = ver_out_q;
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;

endmodule

// File: tb/tb_e32_host_controller.sv
`timescale 1ns/1ps
module tb_e32_host_controller;
  import e32_host_pkg::*;

  localparam int MS = 4;
  localparam int AT = 50;
  localparam int RT = 40;
  localparam int AUX_NORM  = 0;
  localparam int AUX_LOW   = 1;
  localparam int AUX_PULSE = 2;
`ifdef E32_HOST_RESP_CHECK_EN
  localparam bit         CHECK_EN = 1'b1;
  localparam logic [2:0] VER_BAD_ERR = 3'd3;
`else
  localparam bit         CHECK_EN = 1'b0;
  localparam logic [2:0] VER_BAD_ERR = 3'd0;
`endif

  logic        device_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  op_mode = 2'b00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [39:0] cfg_in = 40'd0;
  logic        M0, M1;
  logic        AUX = 1'b1;
  logic [47:0] cfg_out;
  logic [31:0] ver_out;
  logic        done;
  logic [2:0]  err;

  e32_host_controller_if #(.DATA_WIDTH(8)) uart ();

  e32_host_controller #(
    .END_MODE_SWITCH (MS),
    .END_AUX_TIMEOUT (AT),
    .END_RESP_TIMEOUT(RT)
  ) dut (
    .device_clk(device_clk),
    .rst_n     (rst_n),
    .op_mode   (op_mode),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cfg_in    (cfg_in),
    .M0        (M0),
    .M1        (M1),
    .AUX       (AUX),
    .uart      (uart),
    .cfg_out   (cfg_out),
    .ver_out   (ver_out),
    .done      (done),
    .err       (err)
  );

  always #5 device_clk = ~device_clk;

  // UART model: accepts one byte on every third clock.
  int unsigned cyc = 0;
  initial begin
    uart.tx_ready = 1'b0;
    uart.rx_valid = 1'b0;
    uart.rx_data  = 8'h00;
    forever begin
      @(posedge device_clk);
      #1;
      cyc++;
      uart.tx_ready = (cyc % 3 == 0);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [39:0] cfg;
    logic [1:0]  mode;
    int          aux;
    int          nrep;
    logic [47:0] rep;
    logic [2:0]  err;
  } vec_t;

  // Reference model state: last successfully returned responses.
  logic [47:0] cfg_m = 48'd0;
  logic [31:0] ver_m = 32'd0;

  function automatic int tx_count(input logic [2:0] op);
    if (op <= 3'd1) return 6;
    if (op <= 3'd4) return 3;
    return 0;
  endfunction

  function automatic int resp_count(input logic [2:0] op);
    return (op == 3'd3) ? 4 : 6;
  endfunction

  function automatic logic [7:0] tx_exp(input logic [2:0] op, input logic [39:0] cfg, input int k);
    logic [39:0] sh;
    if (op <= 3'd1 && k > 0) begin
      sh = cfg >> (8 * (5 - k));
      return sh[7:0];
    end
    case (op)
      3'd0:    return 8'hC0;
      3'd1:    return 8'hC2;
      3'd2:    return 8'hC1;
      3'd3:    return 8'hC3;
      default: return 8'hC4;
    endcase
  endfunction

  function automatic logic [7:0] rep_byte(input logic [47:0] rep, input int i);
    logic [47:0] sh;
    sh = rep >> (40 - 8 * i);
    return sh[7:0];
  endfunction

  function automatic logic [2:0] predict_err(input vec_t v);
    if (v.op > 3'd4) return 3'd4;
    if (v.aux == AUX_LOW) return 3'd1;
    if (v.op == 3'd4) return 3'd0;
    if (v.nrep < resp_count(v.op)) return 3'd2;
    if (CHECK_EN) begin
      if (v.op <= 3'd1 && v.rep != {tx_exp(v.op, v.cfg, 0), v.cfg}) return 3'd3;
      if (v.op == 3'd2 && v.rep[47:40] != 8'hC1) return 3'd3;
      if (v.op == 3'd3 && v.rep[47:40] != 8'hC3) return 3'd3;
    end
    return 3'd0;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge device_clk);
    chk("cmd_ready", cmd_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] txq[$];
    int   ntx, last_c, done_c, k;
    bit   got_done, m_seen, hold;
    logic [7:0] hold_b;
    ntx = (v.op > 3'd4 || v.aux == AUX_LOW) ? 0 : tx_count(v.op);
    last_c = -1; done_c = -1; got_done = 0; m_seen = 0; hold = 0; hold_b = 8'h00;

    @(negedge device_clk);
    op_mode = v.mode;
    AUX = (v.aux == AUX_LOW) ? 1'b0 : 1'b1;
    repeat (3) @(negedge device_clk);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cfg_in    = v.cfg;
    @(negedge device_clk);
    cmd_valid = 1'b0;
    cfg_in    = {8'($urandom), 32'($urandom)};

    for (int c = 0; c < 1500; c++) begin
      if (done) begin
        got_done = 1;
        done_c = c;
        break;
      end
      if (hold) chk("tx_hold", {uart.tx_valid, uart.tx_data}, {1'b1, hold_b});
      hold = 0;
      if (uart.tx_valid) begin
        if (!m_seen) begin
          m_seen = 1;
          chk("mode_prog", {M1, M0}, 2'b11);
        end
        if (uart.tx_ready) begin
          txq.push_back(uart.tx_data);
          if (txq.size() == ntx) last_c = c;
        end else begin
          hold = 1;
          hold_b = uart.tx_data;
        end
      end
      uart.rx_valid = 1'b0;
      if (last_c >= 0 && v.op != 3'd4) begin
        k = c - last_c - 3;
        if (k >= 0 && k % 2 == 0 && k / 2 < v.nrep) begin
          uart.rx_valid = 1'b1;
          uart.rx_data  = rep_byte(v.rep, k / 2);
        end
      end
      if (v.aux == AUX_PULSE && last_c >= 0)
        AUX = !(c >= last_c + 10 && c < last_c + 30);
      @(negedge device_clk);
    end
    uart.rx_valid = 1'b0;

    if (v.err == 3'd0 && v.op <= 3'd2) cfg_m = v.rep;
    if (v.err == 3'd0 && v.op == 3'd3) ver_m = v.rep[47:16];

    chk("done_seen", got_done, 1'b1);
    if (got_done) begin
      chk("err", err, v.err);
      chk("cfg_out", cfg_out, cfg_m);
      chk("ver_out", ver_out, ver_m);
      chk("mode_restored", {M1, M0}, v.mode);
      chk("tx_count", txq.size(), ntx);
      for (int i = 0; i < ntx && i < txq.size(); i++)
        chk("tx_byte", txq[i], tx_exp(v.op, v.cfg, i));
      if (v.op == 3'd4 && v.aux == AUX_PULSE)
        chk("reset_waits_aux", (last_c >= 0 && done_c > last_c + 30), 1'b1);
      @(negedge device_clk);
      chk("done_pulse", {done, cmd_ready}, 2'b01);
    end
    AUX = 1'b1;
    repeat (3) @(negedge device_clk);
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   need;

  initial begin
    tbl[0] = '{3'd2, 40'h0,          2'b00, AUX_NORM,  6, 48'hC100001A1744, 3'd0};
    tbl[1] = '{3'd0, 40'h12341A1744, 2'b00, AUX_NORM,  6, 48'hC012341A1744, 3'd0};
    tbl[2] = '{3'd4, 40'h0,          2'b00, AUX_PULSE, 0, 48'h0,            3'd0};
    tbl[3] = '{3'd3, 40'h0,          2'b00, AUX_NORM,  2, 48'hC30102030000, 3'd2};
    tbl[4] = '{3'd2, 40'h0,          2'b00, AUX_LOW,   0, 48'h0,            3'd1};
    tbl[5] = '{3'd3, 40'h0,          2'b00, AUX_NORM,  4, 48'hC43227020000, VER_BAD_ERR};
    tbl[6] = '{3'd6, 40'h0,          2'b01, AUX_NORM,  0, 48'h0,            3'd4};
    tbl[7] = '{3'd1, 40'hAABBCCDDEE, 2'b10, AUX_NORM,  6, 48'hC2AABBCCDDEE, 3'd0};

    repeat (3) @(negedge device_clk);
    chk("rst_outputs", {M1, M0, uart.tx_valid, uart.tx_data, done, err, cmd_ready}, 64'd0);
    chk("rst_cfg_out", cfg_out, 48'd0);
    chk("rst_ver_out", ver_out, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_low_after_rst", cmd_ready, 1'b0);
    @(negedge device_clk);
    chk("ready_one_cycle", cmd_ready, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    for (int n = 0; n < 14; n++) begin
      rv.op   = 3'($urandom_range(0, 5));
      rv.cfg  = {8'($urandom), 32'($urandom)};
      rv.mode = 2'($urandom_range(0, 3));
      rv.aux  = (rv.op == 3'd4) ? AUX_PULSE : AUX_NORM;
      need    = resp_count(rv.op);
      case (rv.op)
        3'd0, 3'd1: rv.rep = {tx_exp(rv.op, rv.cfg, 0), rv.cfg};
        3'd2:       rv.rep = {8'hC1, 8'($urandom), 32'($urandom)};
        3'd3:       rv.rep = {8'hC3, 24'($urandom), 16'h0};
        default:    rv.rep = 48'h0;
      endcase
      if ($urandom_range(0, 3) == 0) rv.rep[47:40] = rv.rep[47:40] ^ 8'h5A;
      if (rv.op <= 3'd1 && $urandom_range(0, 3) == 0) rv.rep[7:0] = rv.rep[7:0] ^ 8'h01;
      rv.nrep = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, need - 1)) : need;
      if (rv.op >= 3'd4) rv.nrep = 0;
      rv.err  = predict_err(rv);
      run_vec(rv);
    end

    // Reset in the middle of a read-config command.
    op_mode = 2'b00;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    @(negedge device_clk);
    cmd_valid = 1'b0;
    repeat (15) @(negedge device_clk);
    chk("mid_cmd_mode", {M1, M0}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {M1, M0, uart.tx_valid, done, err, cmd_ready}, 64'd0);
    chk("mid_rst_cfg_out", cfg_out, 48'd0);
    chk("mid_rst_ver_out", ver_out, 32'd0);
    cfg_m = 48'd0;
    ver_m = 32'd0;
    @(negedge device_clk);
    rst_n = 1'b1;
    @(negedge device_clk);
    run_vec(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e32_host_controller.md
Name: e32_host_controller

Overview:
MCU-side initiator for the RF transceiver's MCU interface. It drives M0/M1, tracks AUX, and runs the command protocol: write config (C0/C2 + 5 bytes), read config (C1×3), read version (C3×3) and reset (C4×3). It does this through an external com_uart byte interface (tx/rx byte handshakes) and returns parsed responses and status to the host logic.

Parameters:
DATA_WIDTH, 8, UART byte width
HEAD_DETECT_1, 8'hC0, save-config header
HEAD_DETECT_2, 8'hC2, volatile-config header
RET_CONFIG_DETECT, 8'hC1, read-config opcode and response header
RET_VERSION_DETECT, 8'hC3, read-version opcode and response header
RESET_DETECT, 8'hC4, reset opcode
END_MODE_SWITCH, 15000, cycles waited after AUX high following an M0/M1 change
END_AUX_TIMEOUT, 3000000, max cycles waiting for AUX high
END_RESP_TIMEOUT, 750000, max cycles between response bytes

Ports:
device_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
op_mode  in  2  {M1,M0} applied while idle
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  0 save-cfg, 1 volatile-cfg, 2 read-cfg, 3 read-version, 4 reset, 5-7 illegal
cfg_in  in  40  ADDH,ADDL,SPED,CHAN,OPTION; [39:32] sent first
M0  out  1  mode pin
M1  out  1  mode pin
AUX  in  1  module busy(0)/ready(1), asynchronous
tx_data  out  8  byte to UART
tx_valid  out  1  byte valid
tx_ready  in  1  UART accepts byte when tx_valid&tx_ready
rx_data  in  8  byte from UART
rx_valid  in  1  one-cycle pulse per received byte
cfg_out  out  48  last config response, header in [47:40]
ver_out  out  32  last version response
done  out  1  one-cycle pulse at end of command
err  out  3  0 ok, 1 AUX timeout, 2 response timeout, 3 header mismatch, 4 illegal op; valid with done, held until next command

Behaviour:
- Reset values: {M1,M0}=2'b00, cmd_ready=0 until IDLE is reached one cycle after reset release, tx_valid=0, tx_data=0, cfg_out=0, ver_out=0, done=0, err=0.
- AUX passes through a 2-FF synchronizer. All AUX decisions use the synchronized value (2-cycle latency).
- Counters are 24 bits. Every wait counts from 0, and the expiry compare is counter==END_x-1.
- FSM states: IDLE, ENTER_PROG, SEND, WAIT_RESP, WAIT_AUX, EXIT_PROG, DONE.
- IDLE:
  - {M1,M0}=op_mode, registered one cycle.
  - On cmd_valid&cmd_ready, latch cmd_op and cfg_in and clear err.
  - Illegal op goes directly to DONE with err=4.
- ENTER_PROG:
  - Drive {M1,M0}=11 and wait for AUX=1; expiry gives err=1 and goes to EXIT_PROG.
  - After AUX=1, wait END_MODE_SWITCH cycles, then go to SEND.
- SEND:
  - Byte list per op: cfg ops send header + 5 cfg bytes (6 total); read-cfg, read-version and reset send opcode ×3.
  - tx_valid and tx_data are held stable until tx_ready. The next byte is presented the cycle after acceptance.
  - After the last acceptance: reset op goes to WAIT_AUX; all other ops go to WAIT_RESP.
- WAIT_RESP:
  - Expected counts: cfg ops 6, read-cfg 6, read-version 4.
  - Each rx_valid shifts rx_data into the response shift register and restarts the timeout.
  - On the expected count, the shift register is copied to cfg_out (cfg/read-cfg) or ver_out (version), then go to WAIT_AUX.
  - Timeout gives err=2 and goes to EXIT_PROG; outputs are not updated.
- WAIT_AUX:
  - Reset op: first wait for AUX=0 (bounded by END_AUX_TIMEOUT), then wait for AUX=1.
  - Other ops: wait for AUX=1.
  - Timeout gives err=1.
  - Either way, continue to EXIT_PROG.
- EXIT_PROG: drive {M1,M0}=op_mode sampled at entry, wait AUX=1 (err=1 on timeout, first error kept), then END_MODE_SWITCH cycles, then DONE.
- DONE: pulse done for one cycle, then IDLE.
- rx_valid is ignored outside WAIT_RESP. Extra bytes after the expected count are ignored.
- Reset mid-command: immediate return to the reset values. Partial responses are discarded.
- tx_valid is never asserted outside SEND.

Optional Feature:
- E32_HOST_RESP_CHECK_EN defined:
  - On response completion, check the first byte: it must equal the sent header (cfg ops), RET_CONFIG_DETECT (read-cfg) or RET_VERSION_DETECT (read-version).
  - For cfg ops, bytes 2-6 must also equal cfg_in.
  - Mismatch gives err=3 and outputs stay unchanged; flow continues to WAIT_AUX.
- Undefined: no comparison is made and err is never 3.

Decomposition:
- Shared package e32_host_pkg: opcode enum (OP_SAVE_CFG .. OP_RESET), err code constants, FSM state enum, header byte constants.
- One sub-module: e32_aux_wait, which holds the AUX synchronizer plus the 24-bit wait/timeout counter.
  - Inputs: start, target level, limit.
  - Outputs: hit, timeout.

Test Plan (END_MODE_SWITCH=4, END_AUX_TIMEOUT=50, END_RESP_TIMEOUT=40; model UART tx_ready=1 every 3rd cycle):
- Read-cfg, AUX=1, reply C1 00 00 1A 17 44 -> tx bytes C1 C1 C1, M=11 during command, cfg_out=48'hC100001A1744, done with err=0, M returns to op_mode=00.
- Save-cfg with cfg_in=40'h12341A1744, echo C0 12 34 1A 17 44 -> six tx bytes C0 12 34 1A 17 44, cfg_out updated, err=0.
- Reset op, AUX drops 10 cycles after the last byte and rises 20 cycles later -> done only after AUX rises, err=0, no rx expected.
- Read-version, reply only 2 bytes -> err=2 after 40 idle cycles, ver_out unchanged, M restored.
- AUX held 0 at command start -> err=1 after 50 cycles, no tx_valid ever asserted.
- With E32_HOST_RESP_CHECK_EN, read-version reply C4 32 27 02 -> err=3, ver_out unchanged. Without the macro -> ver_out=32'hC4322702, err=0.
